// File: rtl/qif_neuron_array.sv
// Parallel array of quadratic integrate-and-fire neurons with saturating
// integration, absolute refractory hold and saturating spike counters.
module qif_neuron_array #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int V_TH     = 50,
  parameter int V_RESET  = -20,
  parameter int IN_SHIFT = 2,
  parameter int SQ_SHIFT = 3,
  parameter int REFRAC   = 2,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr_cnt,
  input  logic [CHANNELS*WIDTH-1:0]   I_syn,
  output logic [CHANNELS*WIDTH-1:0]   V_mem,
  output logic [CHANNELS-1:0]         spike,
  output logic [CHANNELS*CNT_W-1:0]   spike_cnt
);

  localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam int SW = 2 * WIDTH + 2;

  localparam logic signed [WIDTH-1:0] VTH = WIDTH'(V_TH);
  localparam logic signed [WIDTH-1:0] VRS = WIDTH'(V_RESET);
  localparam logic [RW-1:0]           RLD = RW'(REFRAC);

  localparam logic signed [WIDTH-1:0] VMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] VMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  genvar k;
  for (k = 0; k < CHANNELS; k++) begin : g_ch
    logic signed [WIDTH-1:0]   v;
    logic signed [WIDTH-1:0]   i_in;
    logic signed [WIDTH-1:0]   i_sh;
    logic signed [WIDTH-1:0]   v_sh;
    logic signed [2*WIDTH-1:0] sq;
    logic signed [SW-1:0]      sum;
    logic signed [WIDTH-1:0]   v_nxt;
    logic [SW-WIDTH:0]         top;
    logic                      ovf;
    logic                      fire;
    logic [RW-1:0]             r;
    logic [CNT_W-1:0]          cnt;
    logic                      s;

    assign i_in = I_syn[k*WIDTH +: WIDTH];
    assign i_sh = i_in >>> IN_SHIFT;
    assign v_sh = v >>> SQ_SHIFT;
    assign sq   = v_sh * v_sh;

    // Wide sum cannot overflow; clamp back to WIDTH afterwards.
    assign sum = {{(SW-WIDTH){v[WIDTH-1]}}, v}
               + {{(SW-WIDTH){i_sh[WIDTH-1]}}, i_sh}
               + {{2{sq[2*WIDTH-1]}}, sq};

    assign top  = sum[SW-1:WIDTH-1];
    assign ovf  = (|top) && !(&top);
    assign fire = (v >= VTH);

    always_comb begin
      v_nxt = sum[WIDTH-1:0];
      if (ovf) v_nxt = sum[SW-1] ? VMIN : VMAX;
    end

    always_ff @(posedge clk) begin
      if (rst_n) begin
        v   <= '0;
        r   <= '0;
        s   <= 1'b0;
        cnt <= '0;
      end else begin
        s <= 1'b0;
        if (en) begin
          if (r != '0) begin
            v <= VRS;
            r <= r - RW'(1);
          end else if (fire) begin
            v <= VRS;
            s <= 1'b1;
            r <= RLD;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
          end else begin
            v <= v_nxt;
          end
        end
        if (clr_cnt) cnt <= '0;
      end
    end

    assign V_mem[k*WIDTH +: WIDTH]     = v;
    assign spike[k]                    = s;
    assign spike_cnt[k*CNT_W +: CNT_W] = cnt;
  end

endmodule

// File: tb/tb_qif_neuron_array.sv
// Bench for qif_neuron_array: two parameterisations against an
// integer reference model, plus directed sequences.
module tb_qif_neuron_array;
  localparam int W  = 8;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr_cnt = 1'b0;
  logic [CH*W-1:0] i_syn = '0;
  logic [CH*W-1:0] v0, v1;
  logic [CH-1:0]   sp0, sp1;
  logic [CH*8-1:0] c0;
  logic [CH*4-1:0] c1;

  always #5 clk = ~clk;

  qif_neuron_array u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
    .I_syn(i_syn), .V_mem(v0), .spike(sp0), .spike_cnt(c0)
  );

  qif_neuron_array #(.V_TH(100), .REFRAC(0), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
    .I_syn(i_syn), .V_mem(v1), .spike(sp1), .spike_cnt(c1)
  );

  int checks = 0;
  int errors = 0;

  int mv[2][CH];
  int mr[2][CH];
  int ms[2][CH];
  int mc[2][CH];
  int th[2] = '{50, 100};
  int rf[2] = '{2, 0};
  int cm[2] = '{255, 15};

  int exp_v[8] = '{10, 21, 35, 61, -20, -20, -20, -1};
  int exp_s[8] = '{0, 0, 0, 0, 1, 0, 0, 0};

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int fdiv(int a, int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int sat(int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int dv(int d, int k);
    if (d == 0) return int'($signed(v0[k*W +: W]));
    return int'($signed(v1[k*W +: W]));
  endfunction

  function automatic int ds(int d, int k);
    return (d == 0) ? int'(sp0[k]) : int'(sp1[k]);
  endfunction

  function automatic int dc(int d, int k);
    if (d == 0) return int'(c0[k*8 +: 8]);
    return int'(c1[k*4 +: 4]);
  endfunction

  task automatic model_step();
    int cur, q;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < CH; k++) begin
        if (rst_n) begin
          mv[d][k] = 0; mr[d][k] = 0;
          ms[d][k] = 0; mc[d][k] = 0;
        end else begin
          ms[d][k] = 0;
          if (en) begin
            if (mr[d][k] > 0) begin
              mv[d][k] = -20;
              mr[d][k] = mr[d][k] - 1;
            end else if (mv[d][k] >= th[d]) begin
              mv[d][k] = -20;
              ms[d][k] = 1;
              mr[d][k] = rf[d];
              if (mc[d][k] < cm[d]) mc[d][k] = mc[d][k] + 1;
            end else begin
              cur = int'($signed(i_syn[k*W +: W]));
              q = fdiv(mv[d][k], 8);
              mv[d][k] = sat(mv[d][k] + fdiv(cur, 4) + q * q);
            end
          end
          if (clr_cnt) mc[d][k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < CH; k++) begin
        check($sformatf("d%0d_v%0d", d, k), dv(d, k), mv[d][k]);
        check($sformatf("d%0d_s%0d", d, k), ds(d, k), ms[d][k]);
        check($sformatf("d%0d_c%0d", d, k), dc(d, k), mc[d][k]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_i(int a, int b, int c, int d);
    i_syn = {W'(d), W'(c), W'(b), W'(a)};
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    en = 1'b0;
    clr_cnt = 1'b0;
    step();
    rst_n = 1'b0;
  endtask

  initial begin
    int found;

    do_reset();
    check("rst_v", dv(0, 0), 0);
    check("rst_c", dc(0, 0), 0);

    // basic trajectory, negative inputs, independent channels
    set_i(40, -1, -128, 5);
    en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      check($sformatf("seq_v%0d", n), dv(0, 0), exp_v[n]);
      check($sformatf("seq_s%0d", n), ds(0, 0), exp_s[n]);
      check($sformatf("neg1_v%0d", n), dv(0, 1), -1);
      if (n == 0) check("neg128_a", dv(0, 2), -32);
      if (n == 1) check("neg128_b", dv(0, 2), -48);
      if (n == 2) check("neg128_c", dv(0, 2), -44);
      if (n >= 4) check("seq_cnt", dc(0, 0), 1);
    end

    // saturation on the high-threshold instance
    do_reset();
    set_i(127, 0, 0, 0);
    en = 1'b1;
    step(); check("sat_v0", dv(1, 0), 31);
    step(); check("sat_v1", dv(1, 0), 71);
    step(); check("sat_v2", dv(1, 0), 127);
    step(); check("sat_v3", dv(1, 0), -20);
    check("sat_s3", ds(1, 0), 1);

    // en gating
    do_reset();
    set_i(40, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      en = (i % 2 == 0);
      step();
      check($sformatf("gate_v%0d", i), dv(0, 0), exp_v[i/2]);
      check($sformatf("gate_s%0d", i), ds(0, 0),
            (i % 2 == 0) ? exp_s[i/2] : 0);
    end

    // counter saturation
    do_reset();
    set_i(127, 127, 127, 127);
    en = 1'b1;
    repeat (1600) step();
    check("cnt_sat0", dc(0, 0), 255);
    check("cnt_sat1", dc(1, 0), 15);

    // clear wins over an increment
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (mr[0][0] == 0 && mv[0][0] >= 50) found = 1;
      else step();
    end
    check("clr_find", found, 1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_spk", ds(0, 0), 1);
    check("clr_cnt", dc(0, 0), 0);

    // reset right after a spike
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (ms[0][0] == 1) found = 1;
    end
    check("rr_find", found, 1);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    check("rr_v", dv(0, 0), 0);
    check("rr_c", dc(0, 0), 0);
    check("rr_s", ds(0, 0), 0);
    set_i(40, 0, 0, 0);
    en = 1'b1;
    step();
    check("rr_next", dv(0, 0), 10);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      clr_cnt = ($urandom_range(0, 49) == 0);
      rst_n   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 0)
        i_syn = $urandom();
      else
        set_i($urandom_range(0, 127), $urandom_range(0, 127),
              $urandom_range(0, 127), $urandom_range(0, 127));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
